// File: rtl/prefetch_throttle_pkg.sv
// Shared types and width helpers for the prefetch throttle controller.
package prefetch_throttle_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_EVAL,
        ST_COOLDOWN
    } throttle_state_t;

    localparam int DEFAULT_MAX_DEGREE = 4;
    localparam int DEGREE_W = $clog2(DEFAULT_MAX_DEGREE + 1);

    function automatic int degree_width(input int max_degree);
        return $clog2(max_degree + 1);
    endfunction

endpackage

// File: rtl/prefetch_throttle_if.sv
// Metadata-store event inputs and prefetcher control outputs of one bank throttle.
interface prefetch_throttle_if #(
    parameter int CNT_W    = 12,
    parameter int DEGREE_W = prefetch_throttle_pkg::DEGREE_W
);
    logic                stall;
    logic                fill_valid;
    logic                fill_prefetch;
    logic                access_valid;
    logic                access_hit;
    logic                access_prefetched_block;
    logic                read_used;
    logic                prefetch_enable;
    logic [DEGREE_W-1:0] prefetch_degree;
    logic                epoch_done;
    logic [CNT_W-1:0]    last_issued;
    logic [CNT_W-1:0]    last_useful;

    modport master (
        output stall, fill_valid, fill_prefetch, access_valid, access_hit,
               access_prefetched_block, read_used,
        input  prefetch_enable, prefetch_degree, epoch_done, last_issued, last_useful
    );

    modport slave (
        input  stall, fill_valid, fill_prefetch, access_valid, access_hit,
               access_prefetched_block, read_used,
        output prefetch_enable, prefetch_degree, epoch_done, last_issued, last_useful
    );
endinterface

// File: rtl/prefetch_throttle_counter.sv
// Saturating event counter; a load restarts it at 0 or 1 depending on the current event.
module prefetch_throttle_counter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_event,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= W'(i_event);
        end else if (i_event && !(&r_count)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/prefetch_throttle.sv
// Per-bank prefetch throttle: measures prefetch accuracy per epoch and adjusts
// the prefetcher degree, disabling it for a cooldown period when accuracy is poor.
module prefetch_throttle
    import prefetch_throttle_pkg::*;
#(
    parameter int CACHE_ID        = 0,
    parameter int BANK_ID         = 0,
    parameter int EPOCH_LEN       = 1024,
    parameter int CNT_W           = 12,
    parameter int MAX_DEGREE      = 4,
    parameter int INIT_DEGREE     = 2,
    parameter int HI_EIGHTHS      = 6,
    parameter int LO_EIGHTHS      = 2,
    parameter int MIN_SAMPLES     = 16,
    parameter int COOLDOWN_EPOCHS = 4
) (
    input logic                clk,
    input logic                reset,
    prefetch_throttle_if.slave bus
);
    localparam int DEG_W   = degree_width(MAX_DEGREE);
    localparam int TIMER_W = $clog2(EPOCH_LEN);
    localparam int PROD_W  = CNT_W + 8;
    localparam int COOL_W  = $clog2(COOLDOWN_EPOCHS + 2);

    if (EPOCH_LEN < 16 || (EPOCH_LEN & (EPOCH_LEN - 1)) != 0 || MAX_DEGREE < 1 ||
        INIT_DEGREE < 1 || INIT_DEGREE > MAX_DEGREE || LO_EIGHTHS >= HI_EIGHTHS ||
        CACHE_ID < 0 || BANK_ID < 0) begin : g_bad_cfg
        $error("prefetch_throttle: invalid parameter set");
    end

    throttle_state_t   r_state, w_state_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic               r_epoch_end;
    logic               r_enable, w_enable_nxt;
    logic [DEG_W-1:0]   r_degree, w_degree_nxt;
    logic [COOL_W-1:0]  r_cool, w_cool_nxt;
    logic [CNT_W-1:0]   r_last_issued, r_last_useful;
    logic [CNT_W-1:0]   w_issued_cnt, w_useful_cnt;
    logic               w_issue_ev, w_useful_ev, w_epoch_last;
    logic [PROD_W-1:0]  w_useful_x8, w_issued_hi, w_issued_lo;
    logic               w_judged, w_acc_hi, w_acc_lo;

    assign w_issue_ev  = !bus.stall && bus.fill_valid && bus.fill_prefetch;
    // read_used is the pre-access value, so only the first demand use of a prefetched line counts
    assign w_useful_ev = !bus.stall && bus.access_valid && bus.access_hit &&
                         bus.access_prefetched_block && !bus.read_used;
    assign w_epoch_last = (r_timer == TIMER_W'(EPOCH_LEN - 1));

    prefetch_throttle_counter #(.W(CNT_W)) u_issued_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_load  (r_epoch_end),
        .i_event (w_issue_ev),
        .o_count (w_issued_cnt)
    );

    prefetch_throttle_counter #(.W(CNT_W)) u_useful_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_load  (r_epoch_end),
        .i_event (w_useful_ev),
        .o_count (w_useful_cnt)
    );

    assign w_useful_x8 = PROD_W'(w_useful_cnt) << 3;
    assign w_issued_hi = PROD_W'(w_issued_cnt) * PROD_W'(HI_EIGHTHS);
    assign w_issued_lo = PROD_W'(w_issued_cnt) * PROD_W'(LO_EIGHTHS);
    assign w_judged    = (32'(w_issued_cnt) >= 32'(MIN_SAMPLES));
    assign w_acc_hi    = (w_useful_x8 >= w_issued_hi);
    assign w_acc_lo    = (w_useful_x8 < w_issued_lo);

    // Reset release is expected to be synchronised to clk upstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_timer       <= '0;
            r_epoch_end   <= 1'b0;
            r_enable      <= 1'b1;
            r_degree      <= DEG_W'(INIT_DEGREE);
            r_cool        <= '0;
            r_last_issued <= '0;
            r_last_useful <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= r_timer + TIMER_W'(1);
            r_epoch_end <= w_epoch_last;
            r_enable    <= w_enable_nxt;
            r_degree    <= w_degree_nxt;
            r_cool      <= w_cool_nxt;
            if (r_epoch_end) begin
                r_last_issued <= w_issued_cnt;
                r_last_useful <= w_useful_cnt;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_enable_nxt = r_enable;
        w_degree_nxt = r_degree;
        w_cool_nxt   = r_cool;
        case (r_state)
            ST_RUN: begin
                if (w_epoch_last) begin
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                w_state_nxt = ST_RUN;
                if (w_judged) begin
                    if (w_acc_hi) begin
                        if (r_degree != DEG_W'(MAX_DEGREE)) begin
                            w_degree_nxt = r_degree + DEG_W'(1);
                        end
                    end else if (w_acc_lo) begin
                        if (r_degree > DEG_W'(1)) begin
                            w_degree_nxt = r_degree - DEG_W'(1);
                        end else if (COOLDOWN_EPOCHS > 0) begin
                            w_enable_nxt = 1'b0;
                            w_cool_nxt   = COOL_W'(COOLDOWN_EPOCHS);
                            w_state_nxt  = ST_COOLDOWN;
                        end
                    end
                end
            end
            ST_COOLDOWN: begin
                if (r_epoch_end) begin
                    if (r_cool <= COOL_W'(1)) begin
                        w_cool_nxt   = '0;
                        w_enable_nxt = 1'b1;
                        w_degree_nxt = DEG_W'(1);
                        w_state_nxt  = ST_RUN;
                    end else begin
                        w_cool_nxt = r_cool - COOL_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign bus.prefetch_enable = r_enable;
    assign bus.prefetch_degree = r_degree;
    assign bus.epoch_done      = r_epoch_end;
    assign bus.last_issued     = r_last_issued;
    assign bus.last_useful     = r_last_useful;
endmodule

// File: tb/tb_prefetch_throttle.sv
// Randomised scoreboard bench: two throttle instances (12-bit and 4-bit counters) share one stimulus stream.
module tb_prefetch_throttle;
    localparam int TB_LEN  = 64;
    localparam int MINS    = 16;
    localparam int HI      = 6;
    localparam int LO      = 2;
    localparam int MAXD    = 4;
    localparam int INITD   = 2;
    localparam int COOL    = 4;

    typedef struct {
        int unsigned iss;
        int unsigned usf;
        int unsigned en;
        int unsigned deg;
    } exp_t;

    logic clk;
    logic reset;
    logic t_stall, t_fv, t_fp, t_av, t_ah, t_apb, t_ru;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    exp_t        q_a[$];
    exp_t        q_s[$];
    int unsigned m_en[2];
    int unsigned m_deg[2];
    int unsigned m_cool[2];
    int unsigned prev_en[2];
    int unsigned prev_deg[2];

    prefetch_throttle_if #(.CNT_W(12), .DEGREE_W(3)) if_a ();
    prefetch_throttle_if #(.CNT_W(4),  .DEGREE_W(3)) if_s ();

    assign if_a.stall = t_stall;  assign if_s.stall = t_stall;
    assign if_a.fill_valid = t_fv;  assign if_s.fill_valid = t_fv;
    assign if_a.fill_prefetch = t_fp;  assign if_s.fill_prefetch = t_fp;
    assign if_a.access_valid = t_av;  assign if_s.access_valid = t_av;
    assign if_a.access_hit = t_ah;  assign if_s.access_hit = t_ah;
    assign if_a.access_prefetched_block = t_apb;  assign if_s.access_prefetched_block = t_apb;
    assign if_a.read_used = t_ru;  assign if_s.read_used = t_ru;

    prefetch_throttle #(
        .CACHE_ID(0), .BANK_ID(0), .EPOCH_LEN(TB_LEN), .CNT_W(12), .MAX_DEGREE(MAXD),
        .INIT_DEGREE(INITD), .HI_EIGHTHS(HI), .LO_EIGHTHS(LO), .MIN_SAMPLES(MINS),
        .COOLDOWN_EPOCHS(COOL)
    ) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));

    prefetch_throttle #(
        .CACHE_ID(1), .BANK_ID(1), .EPOCH_LEN(TB_LEN), .CNT_W(4), .MAX_DEGREE(MAXD),
        .INIT_DEGREE(INITD), .HI_EIGHTHS(HI), .LO_EIGHTHS(LO), .MIN_SAMPLES(MINS),
        .COOLDOWN_EPOCHS(COOL)
    ) dut_s (.clk(clk), .reset(reset), .bus(if_s.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_in(input logic st, input logic fv, input logic fp, input logic av,
                          input logic ah, input logic apb, input logic ru);
        t_stall = st; t_fv = fv; t_fp = fp; t_av = av; t_ah = ah; t_apb = apb; t_ru = ru;
    endtask

    function automatic void mdl_reset();
        for (int d = 0; d < 2; d++) begin
            m_en[d] = 1; m_deg[d] = INITD; m_cool[d] = 0;
            prev_en[d] = 1; prev_deg[d] = INITD;
        end
    endfunction

    // Epoch-level behaviour: totals in, saturated report and new enable/degree out.
    function automatic exp_t mdl_epoch(input int d, input int unsigned fills, input int unsigned useful);
        exp_t e;
        int unsigned cmax = (d == 0) ? 4095 : 15;
        int unsigned i = (fills > cmax) ? cmax : fills;
        int unsigned u = (useful > cmax) ? cmax : useful;
        if (m_en[d] == 0) begin
            m_cool[d] = m_cool[d] - 1;
            if (m_cool[d] == 0) begin
                m_en[d] = 1; m_deg[d] = 1;
            end
        end else if (i >= MINS) begin
            if (u * 8 >= i * HI) begin
                m_deg[d] = (m_deg[d] < MAXD) ? m_deg[d] + 1 : MAXD;
            end else if (u * 8 < i * LO) begin
                if (m_deg[d] > 1) m_deg[d] = m_deg[d] - 1;
                else begin
                    m_en[d] = 0; m_cool[d] = COOL;
                end
            end
        end
        e.iss = i; e.usf = u; e.en = m_en[d]; e.deg = m_deg[d];
        return e;
    endfunction

    task automatic drive_epoch(input int unsigned fills, input int unsigned useful, input int abort_at);
        bit          f_plan[TB_LEN];
        bit          u_plan[TB_LEN];
        int unsigned placed;
        int unsigned c;
        for (int k = 0; k < TB_LEN; k++) begin
            f_plan[k] = 0; u_plan[k] = 0;
        end
        placed = 0;
        if (fills >= 2) begin
            f_plan[0] = 1; f_plan[TB_LEN-1] = 1; placed = 2;
        end
        while (placed < fills) begin
            c = $urandom_range(TB_LEN - 1);
            if (!f_plan[c]) begin f_plan[c] = 1; placed++; end
        end
        placed = 0;
        if (fills > 0 && useful > 0) begin
            do c = $urandom_range(TB_LEN - 1); while (!f_plan[c]);
            u_plan[c] = 1; placed = 1;
        end
        while (placed < useful) begin
            c = $urandom_range(TB_LEN - 1);
            if (!u_plan[c]) begin u_plan[c] = 1; placed++; end
        end
        for (int j = 0; j < TB_LEN; j++) begin
            if (j == abort_at) return;
            if (f_plan[j] || u_plan[j]) begin
                set_in(0, f_plan[j], f_plan[j], u_plan[j], u_plan[j], u_plan[j], 0);
            end else begin
                case ($urandom_range(3))
                    0: set_in(0, 0, 0, 0, 0, 0, 0);
                    1: set_in(1, 1, 1, 1, 1, 1, 0);
                    2: set_in(0, 1, 0, 1, 1, 1, 1);
                    default: set_in(0, 0, 1, 1, 0, 1, 0);
                endcase
            end
            if (j == TB_LEN - 1) begin
                q_a.push_back(mdl_epoch(0, fills, useful));
                q_s.push_back(mdl_epoch(1, fills, useful));
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("a_rst_enable", if_a.prefetch_enable, 1);
        chk("a_rst_degree", if_a.prefetch_degree, INITD);
        chk("a_rst_epoch_done", if_a.epoch_done, 0);
        chk("a_rst_last_issued", if_a.last_issued, 0);
        chk("a_rst_last_useful", if_a.last_useful, 0);
        chk("s_rst_enable", if_s.prefetch_enable, 1);
        chk("s_rst_degree", if_s.prefetch_degree, INITD);
        chk("s_rst_last_issued", if_s.last_issued, 0);
        repeat (3) @(negedge clk);
        q_a.delete();
        q_s.delete();
        mdl_reset();
        reset = 1'b1;
    endtask

    initial begin : mon_a
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && if_a.epoch_done) begin
                chk("a_enable_before_update", if_a.prefetch_enable, prev_en[0]);
                chk("a_degree_before_update", if_a.prefetch_degree, prev_deg[0]);
                @(negedge clk);
                chk("a_epoch_expected", q_a.size() > 0, 1);
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    chk("a_epoch_done_width", if_a.epoch_done, 0);
                    chk("a_last_issued", if_a.last_issued, e.iss);
                    chk("a_last_useful", if_a.last_useful, e.usf);
                    chk("a_enable", if_a.prefetch_enable, e.en);
                    chk("a_degree", if_a.prefetch_degree, e.deg);
                    prev_en[0] = e.en; prev_deg[0] = e.deg;
                end
            end
        end
    end

    initial begin : mon_s
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && if_s.epoch_done) begin
                chk("s_enable_before_update", if_s.prefetch_enable, prev_en[1]);
                chk("s_degree_before_update", if_s.prefetch_degree, prev_deg[1]);
                @(negedge clk);
                chk("s_epoch_expected", q_s.size() > 0, 1);
                if (q_s.size() > 0) begin
                    e = q_s.pop_front();
                    chk("s_last_issued_sat", if_s.last_issued, e.iss);
                    chk("s_last_useful_sat", if_s.last_useful, e.usf);
                    chk("s_enable", if_s.prefetch_enable, e.en);
                    chk("s_degree", if_s.prefetch_degree, e.deg);
                    prev_en[1] = e.en; prev_deg[1] = e.deg;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int unsigned f;
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        mdl_reset();
        #1;
        do_reset();
        for (int k = 0; k < 3; k++) drive_epoch(20, 18, -1);
        drive_epoch(10, 0, -1);
        for (int k = 0; k < 4; k++) drive_epoch(20, 2, -1);
        for (int k = 0; k < 4; k++) drive_epoch(0, $urandom_range(3), -1);
        for (int k = 0; k < 6; k++) begin
            f = $urandom_range(40);
            drive_epoch(f, $urandom_range(f), -1);
        end
        drive_epoch(20, 18, TB_LEN / 2);
        do_reset();
        drive_epoch(17, 5, -1);
        repeat (4) @(negedge clk);
        chk("a_queue_drained", q_a.size(), 0);
        chk("s_queue_drained", q_s.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/prefetch_throttle.md
Name: prefetch_throttle

Overview:
- Per-bank controller that schedules the prefetcher from the cache-line used-bit metadata.
- Counts prefetch fills and first demand uses of prefetched lines over fixed epochs, then raises, lowers or disables the prefetch degree.
- Sits beside the bank's metadata store. Consumes its fill/access/read_used events and drives the prefetcher's enable and degree inputs.

Parameters:
- CACHE_ID, 0, cache instance id (trace only)
- BANK_ID, 0, bank id (trace only)
- EPOCH_LEN, 1024, cycles per evaluation epoch (power of two, ≥16)
- CNT_W, 12, event counter width; counters saturate
- MAX_DEGREE, 4, maximum lines prefetched per trigger (≥1)
- INIT_DEGREE, 2, degree after reset (1..MAX_DEGREE)
- HI_EIGHTHS, 6, accuracy ≥ HI/8 raises degree
- LO_EIGHTHS, 2, accuracy < LO/8 lowers degree (LO < HI)
- MIN_SAMPLES, 16, minimum prefetch fills for an epoch to be judged
- COOLDOWN_EPOCHS, 4, epochs held disabled before re-probe

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  bank pipeline stall; events are ignored while high
- fill_valid  in  1  line fill written to metadata store
- fill_prefetch  in  1  fill was caused by a prefetch
- access_valid  in  1  demand access reached metadata stage
- access_hit  in  1  demand access hit
- access_prefetched_block  in  1  hit line was brought in by prefetch
- read_used  in  1  used bit read from metadata store (valid with access_valid)
- prefetch_enable  out  1  prefetcher may issue
- prefetch_degree  out  clog2(MAX_DEGREE+1)  lines per trigger
- epoch_done  out  1  one-cycle pulse at each evaluation
- last_issued  out  CNT_W  prefetch fills counted in the last epoch
- last_useful  out  CNT_W  useful prefetches counted in the last epoch

Behaviour:
Reset (async assert, sync deassert):
- State RUN, prefetch_enable=1, prefetch_degree=INIT_DEGREE.
- epoch_done=0, last_*=0, all counters 0.

Events (only when ~stall):
- Issue event: fill_valid & fill_prefetch.
- Useful event: access_valid & access_hit & access_prefetched_block & ~read_used.
- A useful event is counted once per line, because the same access sets the used bit.
- Both events in one cycle each increment their own counter.
- Counters saturate at 2^CNT_W−1.

Epoch timer:
- Free-running, counts 0..EPOCH_LEN−1 and wraps.
- Runs regardless of stall and state.

FSM states: RUN, EVAL, COOLDOWN.
- RUN: count events. At timer==EPOCH_LEN−1, go to EVAL.
- EVAL (exactly one cycle):
  - last_issued/last_useful ← counters. epoch_done=1.
  - Counters reload with that cycle's events, so EVAL-cycle events belong to the new epoch.
  - Decision, using widened products and no division (accuracy = U*8 vs I*threshold, with I = issued, U = useful):
    - I < MIN_SAMPLES: no change.
    - U*8 ≥ I*HI_EIGHTHS: degree ← min(degree+1, MAX_DEGREE).
    - U*8 < I*LO_EIGHTHS and degree>1: degree ← degree−1.
    - U*8 < I*LO_EIGHTHS and degree==1: prefetch_enable←0, cooldown counter ← COOLDOWN_EPOCHS, next state COOLDOWN.
    - Otherwise: unchanged.
  - Next state is RUN unless disabling.
- COOLDOWN:
  - Counters still run, but issue events are not expected.
  - epoch_done still pulses at each epoch end; last_* still update.
  - Each epoch end decrements the cooldown counter.
  - When it reaches 0: prefetch_enable←1, degree←1, go to RUN.
- prefetch_degree and prefetch_enable change only on the cycle after EVAL / epoch end. They are registered, so updates are visible one cycle after epoch_done.
- Reset mid-epoch aborts all state immediately; no partial epoch is reported.
- COOLDOWN_EPOCHS=0: re-enable at the same epoch end, i.e. a direct EVAL→RUN with degree 1.

Decomposition:
- Shared package (cache defines): throttle state enum {RUN, EVAL, COOLDOWN} and DEGREE_W = clog2(MAX_DEGREE+1).
- One natural sub-module: prefetch_throttle_counter, a saturating event counter with synchronous load, instanced twice.

Test Plan:
- Reset: hold reset low 3 cycles → enable=1, degree=2, epoch_done=0, last_*=0, asserted asynchronously before any clk edge.
- High accuracy: EPOCH_LEN=64; 20 prefetch fills and 18 useful hits per epoch over 3 epochs → degree 3, 4, 4 (saturates); last_issued=20, last_useful=18.
- Low accuracy to disable: 20 fills, 2 useful per epoch starting at degree 2 → degree 1, then enable=0. The next 4 epoch_done pulses hold enable=0; after the 4th, enable=1 and degree=1.
- Sparse epoch: 10 fills, 0 useful (< MIN_SAMPLES) → degree unchanged; last_issued=10.
- Stall and boundary: events with stall=1 → not counted. An event in the EVAL cycle → appears in the next epoch's last_*. Fills plus useful in the same cycle → both counted.
- Saturation: CNT_W=4 with 20 fills → last_issued=15, with no wrap to a small value.
